// File: rtl/aes_pkg.sv
// Shared AES-128 constants: round count, FSM encoding, RCON, S-box and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  // Byte b of the table sits at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// Combinational round tail: ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] sb_i,    // state after SubBytes
  input  logic [127:0] rk_i,    // round key for this round
  input  logic         last_i,  // final round skips MixColumns
  output logic [127:0] st_o
);

  logic [127:0] sr;

  // Byte r+4c is row r, column c; row r rotates left by r columns.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb_i[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  assign st_o = (last_i ? sr : mix_columns(sr)) ^ rk_i;

endmodule

// File: rtl/subBytes128.sv
// State-wide S-box substitution built from four word substitutors.
module subBytes128 (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  for (genvar i = 0; i < 4; i++) begin : g_word
    subBytes32 u_sub_word (
      .data_i (data_i[127-32*i -: 32]),
      .data_o (data_o[127-32*i -: 32])
    );
  end

endmodule

// File: rtl/subBytes32.sv
// Word-wide S-box substitution (SubWord).
module subBytes32
  import aes_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  assign data_o = {sbox(data_i[31:24]), sbox(data_i[23:16]),
                   sbox(data_i[15:8]),  sbox(data_i[7:0])};

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion.
module aes128_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);

  state_e       state_q;
  logic [127:0] st_q, rk_q;
  logic [3:0]   rnd_q;
  logic         in_ready_q, busy_q, out_valid_q;

  logic [31:0]  rot_w, sub_w, t_w;
  logic [127:0] rk_d, sb, st_d;

  // Key expansion for the round currently being computed.
  assign rot_w = {rk_q[23:0], rk_q[31:24]};

  subBytes32 u_sub_word (
    .data_i (rot_w),
    .data_o (sub_w)
  );

  // Each new word chains off the previous new word.
  always_comb begin
    t_w               = sub_w ^ {rcon(rnd_q), 24'h0};
    rk_d[127:96]      = rk_q[127:96] ^ t_w;
    rk_d[95:64]       = rk_q[95:64] ^ rk_d[127:96];
    rk_d[63:32]       = rk_q[63:32] ^ rk_d[95:64];
    rk_d[31:0]        = rk_q[31:0] ^ rk_d[63:32];
  end

  subBytes128 u_sub_state (
    .data_i (st_q),
    .data_o (sb)
  );

  aes_round_comb u_round (
    .sb_i   (sb),
    .rk_i   (rk_d),
    .last_i (rnd_q == 4'(NR)),
    .st_o   (st_d)
  );

  // Control FSM and datapath registers; handshake outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      st_q        <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            st_q       <= pt ^ key;
            rk_q       <= key;
            rnd_q      <= 4'd1;
            state_q    <= StRound;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRound: begin
          st_q  <= st_d;
          rk_q  <= rk_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'(NR)) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign ct        = st_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench for aes128_enc_iter: directed FIPS-197 vectors, scoreboard-checked outputs.
module tb_aes128_enc_iter;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] pt = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ct;

  logic [31:0]  sb_in = '0;
  logic [31:0]  sb_out;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [127:0] exp_q[$];
  int           acc_times[$];
  logic [7:0]   sref[256];

  aes128_enc_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .busy      (busy)
  );

  subBytes32 u_sb (
    .data_i (sb_in),
    .data_o (sb_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record cycles whose upcoming edge accepts a request.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) acc_times.push_back(cyc);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Reference S-box from the multiplicative inverse plus affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Scoreboard monitor: compare ct on every output handshake.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected none", ct);
        end else begin
          e = exp_q.pop_front();
          chk("ct", ct, e);
        end
      end
    end
  end

  task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e);
    bit ok;
    ok = 1'b0;
    pt = p; key = k; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (ok) exp_q.push_back(e);
    else begin
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (in_ready && exp_q.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic latency(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) n = i;
    end
    chk(name, 128'(n), 128'd10);
  endtask

  initial begin
    int n0, gap;

    // Real falling edge on reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ct, 128'd0);

    for (int b = 0; b < 256; b++) sref[b] = ref_sbox(8'(b));
    for (int i = 0; i < 64; i++) begin
      sb_in = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      #1;
      for (int j = 0; j < 4; j++) chk("sbox", 128'(sb_out[31-8*j -: 8]), 128'(sref[4*i+j]));
    end

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Vector A: latency and in_ready after handshake.
    send(PT_A, KEY_A, CT_A);
    chk("a_busy", 128'(busy), 128'd1);
    chk("a_in_ready_low", 128'(in_ready), 128'd0);
    latency("a_latency");
    @(posedge clk); #1;
    chk("a_in_ready_after", 128'(in_ready), 128'd1);
    chk("a_out_valid_after", 128'(out_valid), 128'd0);

    // Vector B with garbage inputs during rounds, then C back-to-back.
    n0 = acc_times.size();
    send(PT_B, KEY_B, CT_B);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    send(128'd0, 128'd0, CT_Z);
    gap = (acc_times.size() >= n0 + 2) ? acc_times[n0+1] - acc_times[n0] : -1;
    chk("accept_gap", 128'(gap), 128'd12);
    wait_idle();

    // All-zero vector stalled in DONE while a new request waits.
    out_ready = 1'b0;
    send(128'd0, 128'd0, CT_Z);
    latency("z_latency");
    pt = PT_A; key = KEY_A; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("z_stall_valid", 128'(out_valid), 128'd1);
      chk("z_stall_ct", ct, CT_Z);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("z_in_ready_after", 128'(in_ready), 128'd1);
    chk("z_out_valid_after", 128'(out_valid), 128'd0);
    chk("z_no_accept_in_done", 128'(busy), 128'd0);
    @(posedge clk); #1;
    chk("z_next_accept", 128'(busy), 128'd1);
    in_valid = 1'b0;
    exp_q.push_back(CT_A);
    wait_idle();

    // Asynchronous reset during round 5 discards the block.
    send(PT_B, KEY_B, CT_B);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_ct", ct, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pt = PT_B; key = KEY_B; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_accept", 128'(busy), 128'd1);
    in_valid = 1'b0;
    exp_q.push_back(CT_B);
    latency("post_rst_latency");
    wait_idle();

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1);
  end

endmodule
